// File: rtl/instr_fetch_decode_pkg.sv
// Shared types and constants for the fetch/decode control unit.
// Opcodes, register codes, instruction field positions and strobe bundle.
package instr_fetch_decode_pkg;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int REG_HI = 11;
    localparam int REG_LO = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LI    = 4'h1,
        OP_LD    = 4'h2,
        OP_ST    = 4'h3,
        OP_ADD   = 4'h4,
        OP_SUB   = 4'h5,
        OP_AND   = 4'h6,
        OP_OR    = 4'h7,
        OP_XOR   = 4'h8,
        OP_NOT   = 4'h9,
        OP_LIN   = 4'hA,
        OP_PRINT = 4'hB,
        OP_P7SEG = 4'hC,
        OP_JMP   = 4'hD,
        OP_ILLE  = 4'hE,
        OP_ILLF  = 4'hF
    } opcode_e;

    localparam logic [3:0] REG_ACC   = 4'h0;
    localparam logic [3:0] REG_A     = 4'h1;
    localparam logic [3:0] REG_B     = 4'h2;
    localparam logic [3:0] REG_C     = 4'h3;
    localparam logic [3:0] REG_E     = 4'h4;
    localparam logic [3:0] REG_D     = 4'h5;
    localparam logic [3:0] REG_MADDR = 4'hE;
    localparam logic [3:0] REG_ZERO  = 4'hF;

    typedef struct packed {
        logic ld_imm;
        logic ld_ram;
        logic st_ram;
        logic alu_en;
        logic lin;
        logic print;
        logic print7seg;
    } strobe_t;

endpackage

// File: rtl/instr_fetch_decode_if.sv
// ROM read bus plus datapath control strobes of the fetch/decode unit.
// master = control unit side, slave = ROM/datapath side.
interface instr_fetch_decode_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               run;
    logic               hold;
    logic               zero_flag;
    logic [INSTR_W-1:0] out_prom;
    logic [PC_W-1:0]    addr_p;
    logic [PC_W-1:0]    pc;
    logic [3:0]         reg_sel;
    logic [7:0]         imm;
    logic [2:0]         alu_op;
    logic               ld_imm;
    logic               ld_ram;
    logic               st_ram;
    logic               alu_en;
    logic               lin;
    logic               print;
    logic               print7seg;
    logic               instr_valid;
    logic               illegal;

    modport master (
        input  run, hold, zero_flag, out_prom,
        output addr_p, pc, reg_sel, imm, alu_op,
        output ld_imm, ld_ram, st_ram, alu_en,
        output lin, print, print7seg,
        output instr_valid, illegal
    );

    modport slave (
        output run, hold, zero_flag, out_prom,
        input  addr_p, pc, reg_sel, imm, alu_op,
        input  ld_imm, ld_ram, st_ram, alu_en,
        input  lin, print, print7seg,
        input  instr_valid, illegal
    );
endinterface

// File: rtl/instr_fetch_decode_decoder.sv
// Combinational instruction decoder: ir -> strobes, ALU op, illegal flag.
// Strobes here are raw; the top gates them with the EXEC state.
module instr_fetch_decode_decoder
    import instr_fetch_decode_pkg::*;
(
    input  logic [15:0] ir_i,
    output strobe_t     strobes_o,
    output logic [2:0]  alu_op_o,
    output logic        illegal_o
);
    opcode_e    opc;
    logic [3:0] alu_idx;

    assign opc     = opcode_e'(ir_i[OPC_HI:OPC_LO]);
    assign alu_idx = ir_i[OPC_HI:OPC_LO] - 4'd4;

    // Map each opcode onto exactly one strobe (or none).
    always_comb begin
        strobes_o = '0;
        alu_op_o  = 3'd0;
        illegal_o = 1'b0;
        unique case (opc)
            OP_LI:    strobes_o.ld_imm = 1'b1;
            OP_LD:    strobes_o.ld_ram = 1'b1;
            OP_ST:    strobes_o.st_ram = 1'b1;
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR, OP_NOT: begin
                strobes_o.alu_en = 1'b1;
                alu_op_o         = alu_idx[2:0];
            end
            OP_LIN:   strobes_o.lin = 1'b1;
            OP_PRINT: strobes_o.print = 1'b1;
            OP_P7SEG: strobes_o.print7seg = 1'b1;
            OP_ILLE, OP_ILLF: illegal_o = 1'b1;
            default:  strobes_o = '0;
        endcase
    end
endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode control unit: 3-state FETCH/DECODE/EXEC sequencer,
// program counter, instruction register and sticky illegal flag.
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter int              PC_W    = 8,
    parameter int              INSTR_W = 16,
    parameter logic [PC_W-1:0] RST_PC  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_decode_if.master  bus
);
    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    npc_q, npc_d;
    logic [INSTR_W-1:0] ir_q;
    logic               illegal_q;

    strobe_t            dec_strobes;
    logic [2:0]         dec_alu_op;
    logic               dec_illegal;
    logic               in_exec;

    logic [3:0]         fetch_opc;
    logic [3:0]         fetch_reg;
    logic [PC_W-1:0]    fetch_imm;
    logic [PC_W-1:0]    pc_inc;

    instr_fetch_decode_decoder u_dec (
        .ir_i      (ir_q),
        .strobes_o (dec_strobes),
        .alu_op_o  (dec_alu_op),
        .illegal_o (dec_illegal)
    );

    assign fetch_opc = bus.out_prom[OPC_HI:OPC_LO];
    assign fetch_reg = bus.out_prom[REG_HI:REG_LO];
    assign fetch_imm = PC_W'(bus.out_prom[IMM_HI:IMM_LO]);
    assign pc_inc    = pc_q + PC_W'(1);

    // Sequencer next state: run gates only FETCH, hold stretches EXEC.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (bus.run) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   if (!bus.hold) state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Branch target from the word arriving from ROM during DECODE.
    always_comb begin
        npc_d = pc_inc;
        if (fetch_opc == OP_JMP) begin
            if (fetch_reg == REG_ZERO) begin
                npc_d = bus.zero_flag ? fetch_imm : pc_inc;
            end else begin
                npc_d = fetch_imm;
            end
        end
    end

    // State, pc, ir and sticky illegal; pc advances as EXEC retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RST_PC;
            npc_q     <= RST_PC;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                ir_q  <= bus.out_prom;
                npc_q <= npc_d;
            end
            if (in_exec && !bus.hold) begin
                pc_q <= npc_q;
            end
            if (in_exec && dec_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign in_exec = (state_q == S_EXEC);

    assign bus.addr_p      = pc_q;
    assign bus.pc          = pc_q;
    assign bus.reg_sel     = ir_q[REG_HI:REG_LO];
    assign bus.imm         = ir_q[IMM_HI:IMM_LO];
    assign bus.alu_op      = dec_alu_op;
    assign bus.ld_imm      = in_exec & dec_strobes.ld_imm;
    assign bus.ld_ram      = in_exec & dec_strobes.ld_ram;
    assign bus.st_ram      = in_exec & dec_strobes.st_ram;
    assign bus.alu_en      = in_exec & dec_strobes.alu_en;
    assign bus.lin         = in_exec & dec_strobes.lin;
    assign bus.print       = in_exec & dec_strobes.print;
    assign bus.print7seg   = in_exec & dec_strobes.print7seg;
    assign bus.instr_valid = in_exec;
    assign bus.illegal     = illegal_q | (in_exec & dec_illegal);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: opcode table plus
// hand-written multi-cycle sequences (hold, wrap, illegal, reset).
module tb_instr_fetch_decode;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] rom [256];

    int n_pass  = 0;
    int n_total = 0;

    instr_fetch_decode_if bus ();

    instr_fetch_decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.out_prom <= rom[bus.addr_p];

    typedef struct {
        logic [15:0] instr;
        logic        zf;
        logic [6:0]  strb;
        logic [2:0]  alu_op;
        logic [3:0]  reg_sel;
        logic [7:0]  imm;
        logic [7:0]  npc;
        logic        ill;
    } vec_t;

    vec_t vecs [17];

    function automatic logic [6:0] strobes();
        return {bus.ld_imm, bus.ld_ram, bus.st_ram, bus.alu_en,
                bus.lin, bus.print, bus.print7seg};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        rom[0] = v.instr;
        bus.zero_flag = v.zf;
        do_reset();
        tick();
        tick();
        chk($sformatf("v%0d_valid", idx), 32'(bus.instr_valid), 32'd1);
        chk($sformatf("v%0d_strb", idx), 32'(strobes()), 32'(v.strb));
        chk($sformatf("v%0d_reg", idx), 32'(bus.reg_sel), 32'(v.reg_sel));
        chk($sformatf("v%0d_imm", idx), 32'(bus.imm), 32'(v.imm));
        chk($sformatf("v%0d_ill", idx), 32'(bus.illegal), 32'(v.ill));
        if (v.strb[3]) begin
            chk($sformatf("v%0d_aluop", idx), 32'(bus.alu_op), 32'(v.alu_op));
        end
        tick();
        chk($sformatf("v%0d_npc", idx), 32'(bus.addr_p), 32'(v.npc));
        chk($sformatf("v%0d_fetch", idx), 32'(bus.instr_valid), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{16'h0000, 1'b0, 7'b0000000, 3'd0, 4'h0, 8'h00, 8'h01, 1'b0};
        vecs[1]  = '{16'h1004, 1'b0, 7'b1000000, 3'd0, 4'h0, 8'h04, 8'h01, 1'b0};
        vecs[2]  = '{16'h2312, 1'b0, 7'b0100000, 3'd0, 4'h3, 8'h12, 8'h01, 1'b0};
        vecs[3]  = '{16'h3E05, 1'b0, 7'b0010000, 3'd0, 4'hE, 8'h05, 8'h01, 1'b0};
        vecs[4]  = '{16'h4200, 1'b0, 7'b0001000, 3'd0, 4'h2, 8'h00, 8'h01, 1'b0};
        vecs[5]  = '{16'h5100, 1'b0, 7'b0001000, 3'd1, 4'h1, 8'h00, 8'h01, 1'b0};
        vecs[6]  = '{16'h6033, 1'b0, 7'b0001000, 3'd2, 4'h0, 8'h33, 8'h01, 1'b0};
        vecs[7]  = '{16'h7000, 1'b0, 7'b0001000, 3'd3, 4'h0, 8'h00, 8'h01, 1'b0};
        vecs[8]  = '{16'h8000, 1'b0, 7'b0001000, 3'd4, 4'h0, 8'h00, 8'h01, 1'b0};
        vecs[9]  = '{16'h9400, 1'b0, 7'b0001000, 3'd5, 4'h4, 8'h00, 8'h01, 1'b0};
        vecs[10] = '{16'hA500, 1'b0, 7'b0000100, 3'd0, 4'h5, 8'h00, 8'h01, 1'b0};
        vecs[11] = '{16'hB000, 1'b0, 7'b0000010, 3'd0, 4'h0, 8'h00, 8'h01, 1'b0};
        vecs[12] = '{16'hC0FF, 1'b0, 7'b0000001, 3'd0, 4'h0, 8'hFF, 8'h01, 1'b0};
        vecs[13] = '{16'hD010, 1'b0, 7'b0000000, 3'd0, 4'h0, 8'h10, 8'h10, 1'b0};
        vecs[14] = '{16'hDF20, 1'b0, 7'b0000000, 3'd0, 4'hF, 8'h20, 8'h01, 1'b0};
        vecs[15] = '{16'hDF20, 1'b1, 7'b0000000, 3'd0, 4'hF, 8'h20, 8'h20, 1'b0};
        vecs[16] = '{16'hF123, 1'b0, 7'b0000000, 3'd0, 4'h1, 8'h23, 8'h01, 1'b1};

        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        bus.run = 1'b1;
        bus.hold = 1'b0;
        bus.zero_flag = 1'b0;
        @(negedge clk);

        // reset state and fetch sequence: NOP then LI ACC 4
        rom[0] = 16'h0000;
        rom[1] = 16'h1004;
        do_reset();
        chk("rst_addr", 32'(bus.addr_p), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_strb", 32'(strobes()), 32'd0);
        chk("rst_ill", 32'(bus.illegal), 32'd0);
        chk("rst_aluop", 32'(bus.alu_op), 32'd0);
        chk("rst_ir", 32'({bus.reg_sel, bus.imm}), 32'd0);
        tick();
        chk("seq_addr1", 32'(bus.addr_p), 32'd0);
        tick();
        chk("seq_addr2", 32'(bus.addr_p), 32'd0);
        tick();
        chk("seq_addr3", 32'(bus.addr_p), 32'd1);
        tick();
        tick();
        chk("seq_ldimm", 32'(bus.ld_imm), 32'd1);
        chk("seq_imm", 32'(bus.imm), 32'd4);
        chk("seq_reg", 32'(bus.reg_sel), 32'd0);

        // run=0 freezes in FETCH
        bus.run = 1'b0;
        do_reset();
        tick();
        tick();
        chk("run0_valid", 32'(bus.instr_valid), 32'd0);
        chk("run0_addr", 32'(bus.addr_p), 32'd0);
        bus.run = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);
        bus.zero_flag = 1'b0;

        // hold stretches EXEC to three cycles
        rom[0] = 16'h4200;
        do_reset();
        tick();
        bus.hold = 1'b1;
        tick();
        chk("hold_e1", 32'({bus.alu_en, bus.instr_valid}), 32'd3);
        tick();
        chk("hold_e2", 32'({bus.alu_en, bus.instr_valid}), 32'd3);
        chk("hold_pc2", 32'(bus.pc), 32'd0);
        tick();
        chk("hold_e3", 32'({bus.alu_en, bus.instr_valid}), 32'd3);
        chk("hold_reg", 32'(bus.reg_sel), 32'd2);
        bus.hold = 1'b0;
        tick();
        chk("hold_done", 32'(bus.instr_valid), 32'd0);
        chk("hold_pc", 32'(bus.pc), 32'd1);

        // pc wrap FF -> 00
        rom[0] = 16'hD0FF;
        rom[8'hFF] = 16'h0000;
        do_reset();
        tick();
        tick();
        tick();
        chk("wrap_ff", 32'(bus.addr_p), 32'hFF);
        tick();
        tick();
        chk("wrap_nop", 32'(bus.instr_valid), 32'd1);
        tick();
        chk("wrap_00", 32'(bus.addr_p), 32'h00);
        chk("wrap_ill", 32'(bus.illegal), 32'd0);

        // illegal opcode is sticky until reset
        rom[0] = 16'hE000;
        rom[1] = 16'h1004;
        do_reset();
        tick();
        tick();
        chk("ill_now", 32'({bus.illegal, bus.instr_valid}), 32'd3);
        chk("ill_strb", 32'(strobes()), 32'd0);
        tick();
        chk("ill_fetch", 32'({bus.illegal, bus.addr_p}), 32'h101);
        tick();
        tick();
        chk("ill_next", 32'({bus.illegal, bus.ld_imm}), 32'd3);
        tick();
        chk("ill_held", 32'(bus.illegal), 32'd1);
        do_reset();
        chk("ill_clr", 32'(bus.illegal), 32'd0);

        // reset in DECODE
        rom[0] = 16'hD055;
        do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstd_valid", 32'(bus.instr_valid), 32'd0);
        chk("rstd_addr", 32'(bus.addr_p), 32'd0);
        tick();
        tick();
        tick();
        chk("rstd_jmp", 32'(bus.addr_p), 32'h55);

        // reset in EXEC while hold=1
        rom[0] = 16'h1004;
        do_reset();
        tick();
        bus.hold = 1'b1;
        tick();
        chk("rste_pre", 32'(bus.ld_imm), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.hold = 1'b0;
        chk("rste_strb", 32'(strobes()), 32'd0);
        chk("rste_valid", 32'(bus.instr_valid), 32'd0);
        chk("rste_addr", 32'(bus.addr_p), 32'd0);
        chk("rste_ir", 32'({bus.reg_sel, bus.imm}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
